alu_acumulador: RTL and testbench
=================================

Name: alu_acumulador

Overview:
- Sequencing stage that sits directly upstream of, and feeds, the team's combinational 4-bit ALU.
- Accepts commands through a valid/ready handshake and holds the accumulator ACC.
- Drives the ALU's A/B/SEL inputs, then registers the ALU result and its four flags back into ACC and FLAGS.
- A command can repeat its operation REP+1 times, e.g. repeated add for small multiplies.

Parameters:
WIDTH, 4, data width of ACC/operand; must equal the ALU data width.
REP_W, 2, width of the repeat-count field.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  reset, asynchronous, active-low.
CMD_VALID  in  1  command present.
CMD_READY  out  1  block can accept a command.
CMD_LOAD  in  1  1 = load CMD_DATO into ACC; 0 = ALU operation.
CMD_SEL  in  3  ALU operation code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nand, 110 xnor, 111 nor.
CMD_DATO  in  WIDTH  operand B, or the load value.
CMD_REP  in  REP_W  extra repetitions; the operation is applied CMD_REP+1 times.
ALU_A  out  WIDTH  to ALU input A; equals ACC.
ALU_B  out  WIDTH  to ALU input B; equals the latched operand.
ALU_SEL  out  3  to ALU SEL; equals the latched operation code.
ALU_RES  in  WIDTH  from ALU result.
ALU_CARRY, ALU_OVF, ALU_ZERO, ALU_SIGNO  in  1 each  ALU flags.
ACC  out  WIDTH  accumulator.
FLAGS  out  4  {CARRY,OVERFLOW,ZERO,SIGNO} of the last update.
OVF_STICKY  out  1  set by any overflowing step.
CLR_STICKY  in  1  synchronous clear of OVF_STICKY.
RES_VALID  out  1  one-cycle pulse when a command completes.
BUSY  out  1  state != IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; ACC, FLAGS, OVF_STICKY, latched operand/opcode and repeat counter all = 0.
  - RES_VALID=0, BUSY=0, CMD_READY=1.
  - Asserting reset mid-command aborts it: no RES_VALID, all registers return to reset values.
- Output decode:
  - CMD_READY = (state==IDLE).
  - RES_VALID = (state==DONE).
  - ALU_A/ALU_B/ALU_SEL come straight from registers, held stable in every state.
- IDLE, on CMD_VALID & CMD_READY:
  - CMD_LOAD=1: ACC<=CMD_DATO; FLAGS<={0,0,CMD_DATO==0,CMD_DATO[WIDTH-1]}; OVF_STICKY unchanged; go to DONE.
  - CMD_LOAD=0: latch CMD_SEL and CMD_DATO; CNT<=CMD_REP; go to EXEC.
- EXEC, every cycle:
  - ACC<=ALU_RES.
  - FLAGS<={ALU_CARRY,ALU_OVF,ALU_ZERO,ALU_SIGNO}.
  - ALU_OVF=1 sets OVF_STICKY.
  - If CNT==0 go to DONE, else CNT<=CNT-1 and stay in EXEC.
- DONE: one cycle, RES_VALID=1; then IDLE unconditionally.
- Latency, counted from the accepting edge:
  - Op command: REP+1 EXEC cycles, then 1 DONE cycle.
  - Load command: DONE only.
  - Next accept is possible in the cycle after DONE.
- Commands presented while BUSY are not captured; CMD_DATO/CMD_SEL changes during EXEC have no effect.
- Arithmetic: all arithmetic is performed by the ALU. ACC wraps modulo 2^WIDTH with no saturation. For sub, CARRY is the borrow from the ALU.
- CLR_STICKY:
  - Clears OVF_STICKY next edge.
  - If the same edge also has an EXEC step with ALU_OVF=1, the set wins and OVF_STICKY stays 1.
- FLAGS and ACC hold their values in IDLE and DONE.

Test Plan:
- Reset: pulse RST_N low between edges, release -> immediately ACC=0, FLAGS=0000, CMD_READY=1, RES_VALID=0, BUSY=0, no clock needed for the reset values.
- LOAD 5, then ADD DATO=3 REP=0 -> one EXEC cycle, ACC=8, FLAGS=0101 (carry0, ovf1, zero0, signo1), OVF_STICKY=1, RES_VALID high for exactly one cycle.
- LOAD 1, then ADD DATO=1 REP=3 -> four EXEC cycles, RES_VALID in the 5th cycle after accept, ACC=5, FLAGS=0000; CMD_VALID with CMD_DATO=7 held during BUSY is ignored.
- LOAD 3, SUB DATO=3 REP=0 -> ACC=0, FLAGS=0010; then SUB DATO=1 -> ACC=F, FLAGS=1001 (borrow, signo).
- Start ADD DATO=1 REP=3 and assert RST_N low in the 2nd EXEC cycle -> ACC=0, no RES_VALID, CMD_READY=1 after release.
- Sticky handling:
  - With OVF_STICKY=0, LOAD 7, then ADD DATO=1 with CLR_STICKY held high during the EXEC cycle -> OVF_STICKY=1 (set wins).
  - Then CLR_STICKY alone -> OVF_STICKY=0 next edge.

Source files
------------

// File: rtl/alu_acumulador.sv
// alu_acumulador: command sequencer and accumulator that sits in front of
// the combinational 4-bit ALU.
// It accepts commands over a valid/ready handshake and drives the ALU
// operands from its own registers. It then writes the ALU result and flags
// back into the accumulator.
// An operation command is applied CMD_REP+1 times in consecutive cycles,
// which allows repeated add to be used for small multiplies.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command; ACC/FLAGS hold
// EXEC  | one ALU step per cycle; ACC/FLAGS take the ALU result/flags
// DONE  | single-cycle RES_VALID pulse, then back to IDLE
module alu_acumulador #(
  parameter int WIDTH = 4,
  parameter int REP_W = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_LOAD,
  input  logic [2:0]       CMD_SEL,
  input  logic [WIDTH-1:0] CMD_DATO,
  input  logic [REP_W-1:0] CMD_REP,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [2:0]       ALU_SEL,
  input  logic [WIDTH-1:0] ALU_RES,
  input  logic             ALU_CARRY,
  input  logic             ALU_OVF,
  input  logic             ALU_ZERO,
  input  logic             ALU_SIGNO,
  output logic [WIDTH-1:0] ACC,
  output logic [3:0]       FLAGS,
  output logic             OVF_STICKY,
  input  logic             CLR_STICKY,
  output logic             RES_VALID,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]         flags_q, flags_d;
  logic               sticky_q, sticky_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2:0]         sel_q, sel_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;

  logic               accept;

  assign accept = CMD_VALID && (state_q == IDLE);

  // Next-state and datapath update; every register holds unless a rule below fires.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;
    opb_d    = opb_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;

    // A clear can act in any state. A later overflow in EXEC overrides it.
    if (CLR_STICKY) begin
      sticky_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (CMD_LOAD) begin
            acc_d   = CMD_DATO;
            flags_d = {1'b0, 1'b0, (CMD_DATO == '0), CMD_DATO[WIDTH-1]};
            state_d = DONE;
          end else begin
            opb_d   = CMD_DATO;
            sel_d   = CMD_SEL;
            cnt_d   = CMD_REP;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        acc_d   = ALU_RES;
        flags_d = {ALU_CARRY, ALU_OVF, ALU_ZERO, ALU_SIGNO};
        if (ALU_OVF) begin
          sticky_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - REP_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; an async reset aborts any command in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      flags_q  <= '0;
      sticky_q <= 1'b0;
      opb_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      opb_q    <= opb_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  assign CMD_READY  = (state_q == IDLE);
  assign RES_VALID  = (state_q == DONE);
  assign BUSY       = (state_q != IDLE);
  assign ALU_A      = acc_q;
  assign ALU_B      = opb_q;
  assign ALU_SEL    = sel_q;
  assign ACC        = acc_q;
  assign FLAGS      = flags_q;
  assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_alu_acumulador.sv
// Directed bench for alu_acumulador, with a behavioural model of the 4-bit ALU attached.
module tb_alu_acumulador;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic       CMD_LOAD = 1'b0;
  logic [2:0] CMD_SEL = 3'd0;
  logic [3:0] CMD_DATO = 4'd0;
  logic [1:0] CMD_REP = 2'd0;
  logic [3:0] ALU_A, ALU_B;
  logic [2:0] ALU_SEL;
  logic [3:0] ALU_RES;
  logic       ALU_CARRY, ALU_OVF, ALU_ZERO, ALU_SIGNO;
  logic [3:0] ACC;
  logic [3:0] FLAGS;
  logic       OVF_STICKY;
  logic       CLR_STICKY = 1'b0;
  logic       RES_VALID;
  logic       BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  alu_acumulador #(.WIDTH(4), .REP_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_LOAD(CMD_LOAD),
    .CMD_SEL(CMD_SEL), .CMD_DATO(CMD_DATO), .CMD_REP(CMD_REP),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SEL(ALU_SEL),
    .ALU_RES(ALU_RES), .ALU_CARRY(ALU_CARRY), .ALU_OVF(ALU_OVF),
    .ALU_ZERO(ALU_ZERO), .ALU_SIGNO(ALU_SIGNO),
    .ACC(ACC), .FLAGS(FLAGS), .OVF_STICKY(OVF_STICKY), .CLR_STICKY(CLR_STICKY),
    .RES_VALID(RES_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Behavioural 4-bit ALU; for sub, CARRY is the borrow.
  logic [4:0] sum5;
  always_comb begin
    sum5      = {1'b0, ALU_A} + {1'b0, ALU_B};
    ALU_RES   = 4'd0;
    ALU_CARRY = 1'b0;
    ALU_OVF   = 1'b0;
    case (ALU_SEL)
      3'd0: begin
        ALU_RES   = sum5[3:0];
        ALU_CARRY = sum5[4];
        ALU_OVF   = (ALU_A[3] == ALU_B[3]) && (sum5[3] != ALU_A[3]);
      end
      3'd1: begin
        ALU_RES   = ALU_A - ALU_B;
        ALU_CARRY = (ALU_A < ALU_B);
        ALU_OVF   = (ALU_A[3] != ALU_B[3]) && (ALU_RES[3] != ALU_A[3]);
      end
      3'd2: ALU_RES = ALU_A & ALU_B;
      3'd3: ALU_RES = ALU_A | ALU_B;
      3'd4: ALU_RES = ALU_A ^ ALU_B;
      3'd5: ALU_RES = ~(ALU_A & ALU_B);
      3'd6: ALU_RES = ~(ALU_A ^ ALU_B);
      default: ALU_RES = ~(ALU_A | ALU_B);
    endcase
    ALU_ZERO  = (ALU_RES == 4'd0);
    ALU_SIGNO = ALU_RES[3];
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic load, input logic [2:0] sel, input logic [3:0] dato,
                       input logic [1:0] rep);
    CMD_VALID = 1'b1;
    CMD_LOAD  = load;
    CMD_SEL   = sel;
    CMD_DATO  = dato;
    CMD_REP   = rep;
    step();
    CMD_VALID = 1'b0;
  endtask

  initial begin
    // Reset pulse between edges; values must appear without a clock.
    #1 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    #1;
    check("rst_acc",   ACC, 8'h0);
    check("rst_flags", FLAGS, 8'h0);
    check("rst_ready", CMD_READY, 8'h1);
    check("rst_resv",  RES_VALID, 8'h0);
    check("rst_busy",  BUSY, 8'h0);
    check("rst_stk",   OVF_STICKY, 8'h0);

    // LOAD 5, then ADD 3 REP 0.
    issue(1'b1, 3'd0, 4'd5, 2'd0);
    check("ld5_resv", RES_VALID, 8'h1);
    check("ld5_acc",  ACC, 8'h5);
    check("ld5_flags", FLAGS, 8'h0);
    step();
    check("ld5_idle", CMD_READY, 8'h1);
    issue(1'b0, 3'd0, 4'd3, 2'd0);
    check("add_busy", BUSY, 8'h1);
    check("add_resv_exec", RES_VALID, 8'h0);
    check("add_alub", ALU_B, 8'h3);
    check("add_alusel", ALU_SEL, 8'h0);
    step();
    check("add_acc",   ACC, 8'h8);
    check("add_flags", FLAGS, 8'h5);
    check("add_stk",   OVF_STICKY, 8'h1);
    check("add_resv",  RES_VALID, 8'h1);
    step();
    check("add_resv_pulse", RES_VALID, 8'h0);
    check("add_hold_acc", ACC, 8'h8);

    // LOAD 1, ADD 1 REP 3, with an ignored LOAD 7 held during BUSY.
    issue(1'b1, 3'd0, 4'd1, 2'd0);
    step();
    issue(1'b0, 3'd0, 4'd1, 2'd3);
    CMD_VALID = 1'b1;
    CMD_LOAD  = 1'b1;
    CMD_DATO  = 4'd7;
    check("rep_cyc1_resv", RES_VALID, 8'h0);
    check("rep_cyc1_ready", CMD_READY, 8'h0);
    step();
    check("rep_cyc2_acc", ACC, 8'h2);
    check("rep_cyc2_alub", ALU_B, 8'h1);
    check("rep_cyc2_resv", RES_VALID, 8'h0);
    step();
    check("rep_cyc3_acc", ACC, 8'h3);
    check("rep_cyc3_resv", RES_VALID, 8'h0);
    step();
    check("rep_cyc4_acc", ACC, 8'h4);
    check("rep_cyc4_resv", RES_VALID, 8'h0);
    step();
    check("rep_done_resv", RES_VALID, 8'h1);
    check("rep_done_acc", ACC, 8'h5);
    check("rep_done_flags", FLAGS, 8'h0);
    CMD_VALID = 1'b0;
    step();
    check("rep_idle_acc", ACC, 8'h5);
    check("rep_idle_ready", CMD_READY, 8'h1);

    // LOAD 3, SUB 3 -> 0, then SUB 1 -> F with borrow.
    issue(1'b1, 3'd0, 4'd3, 2'd0);
    step();
    issue(1'b0, 3'd1, 4'd3, 2'd0);
    step();
    check("sub0_acc", ACC, 8'h0);
    check("sub0_flags", FLAGS, 8'h2);
    step();
    issue(1'b0, 3'd1, 4'd1, 2'd0);
    step();
    check("subf_acc", ACC, 8'hF);
    check("subf_flags", FLAGS, 8'h9);
    step();

    // Abort ADD 1 REP 3 by reset in the 2nd EXEC cycle.
    issue(1'b0, 3'd0, 4'd1, 2'd3);
    step();
    check("abort_busy_pre", BUSY, 8'h1);
    #1 RST_N = 1'b0;
    #1;
    check("abort_acc", ACC, 8'h0);
    check("abort_busy", BUSY, 8'h0);
    #1 RST_N = 1'b1;
    #1;
    check("abort_ready", CMD_READY, 8'h1);
    check("abort_alub", ALU_B, 8'h0);
    step();
    check("abort_no_resv1", RES_VALID, 8'h0);
    step();
    check("abort_no_resv2", RES_VALID, 8'h0);
    check("abort_acc_hold", ACC, 8'h0);
    check("abort_stk", OVF_STICKY, 8'h0);

    // Sticky: overflow step wins over a simultaneous clear; then clear alone.
    issue(1'b1, 3'd0, 4'd7, 2'd0);
    step();
    issue(1'b0, 3'd0, 4'd1, 2'd0);
    CLR_STICKY = 1'b1;
    step();
    CLR_STICKY = 1'b0;
    check("stk_set_wins", OVF_STICKY, 8'h1);
    check("stk_acc", ACC, 8'h8);
    step();
    check("stk_hold", OVF_STICKY, 8'h1);
    CLR_STICKY = 1'b1;
    step();
    CLR_STICKY = 1'b0;
    check("stk_clear", OVF_STICKY, 8'h0);
    check("stk_clear_acc", ACC, 8'h8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
